// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_scan_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, SHOW, BLANK} state_t;

   // Segment bit positions on the a..g bus (pre-polarity)
   localparam int SEG_A = 6;
   localparam int SEG_B = 5;
   localparam int SEG_C = 4;
   localparam int SEG_D = 3;
   localparam int SEG_E = 2;
   localparam int SEG_F = 1;
   localparam int SEG_G = 0;

   localparam int SEG_W = SEG_A - SEG_G + 1;

   // All segments dark, before the board polarity is applied
   localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/seg_dwell_timer.sv
// Loadable down-counter; done marks the last cycle of the loaded interval.
module seg_dwell_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   // Load wins over counting so back-to-back intervals need no idle cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)              cnt <= '0;
      else if (load)         cnt <= load_val;
      else if (cnt != '0)    cnt <= cnt - 1'b1;
   end

   assign done = (cnt == W'(1));

endmodule

// File: rtl/seg_scan_ctrl.sv
// Frame scheduler time-sharing one segment bus across NUM_DIGITS digit selects.
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIGITS     = 8,
   parameter int DWELL_CYCLES   = 6000,
   parameter int BLANK_CYCLES   = 48,
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit DIG_ACTIVE_LOW = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic [7*NUM_DIGITS-1:0] digits_in,
   output logic [SEG_W-1:0]        seg_out,
   output logic [NUM_DIGITS-1:0]   dig_sel,
   output logic                    frame_start,
   output logic                    busy
);

   localparam int CW = $clog2(max2(DWELL_CYCLES, BLANK_CYCLES) + 1);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [SEG_W-1:0]      SEG_IDLE = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
   localparam logic [NUM_DIGITS-1:0] DIG_IDLE = DIG_ACTIVE_LOW ? '1 : '0;
   localparam logic [IW-1:0]         LAST     = IW'(NUM_DIGITS - 1);
   localparam logic [CW-1:0]         DWELL_V  = CW'(DWELL_CYCLES);
   localparam logic [CW-1:0]         BLANK_V  = CW'(BLANK_CYCLES);

   state_t                             state, state_nx;
   logic [IW-1:0]                      idx, idx_nx;
   logic [NUM_DIGITS-1:0][SEG_W-1:0]   shadow, shadow_nx;
   logic                               tmr_load, tmr_done, adv;
   logic [CW-1:0]                      tmr_val;
   logic [SEG_W-1:0]                   seg_nx;
   logic [NUM_DIGITS-1:0]              dig_nx;

   seg_dwell_timer #(.W(CW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // Next state, index, snapshot and timer reload; end-of-digit handling is shared
   always_comb begin
      state_nx  = state;
      idx_nx    = idx;
      shadow_nx = shadow;
      tmr_load  = 1'b0;
      tmr_val   = DWELL_V;
      adv       = 1'b0;
      unique case (state)
         IDLE:  if (enable) state_nx = LOAD;
         LOAD: begin
            shadow_nx = digits_in;
            idx_nx    = '0;
            state_nx  = SHOW;
            tmr_load  = 1'b1;
         end
         SHOW: if (tmr_done) begin
            if (BLANK_CYCLES != 0) begin
               state_nx = BLANK;
               tmr_load = 1'b1;
               tmr_val  = BLANK_V;
            end else begin
               adv = 1'b1;
            end
         end
         BLANK: if (tmr_done) adv = 1'b1;
      endcase
      // A frame always finishes every digit; enable only decides what follows it
      if (adv) begin
         if (idx != LAST) begin
            idx_nx   = idx + 1'b1;
            state_nx = SHOW;
            tmr_load = 1'b1;
            tmr_val  = DWELL_V;
         end else if (enable) begin
            state_nx = LOAD;
         end else begin
            state_nx = IDLE;
         end
      end
   end

   // Output drive decoded from the upcoming state so the pins are pure flops
   always_comb begin
      seg_nx = SEG_IDLE;
      dig_nx = DIG_IDLE;
      if (state_nx == SHOW) begin
         seg_nx = SEG_ACTIVE_LOW ? ~shadow_nx[idx_nx] : shadow_nx[idx_nx];
         dig_nx = NUM_DIGITS'(1) << idx_nx;
         if (DIG_ACTIVE_LOW) dig_nx = ~dig_nx;
      end
   end

   // State and registered outputs; reset blanks the pins without waiting for a clock
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         idx         <= '0;
         shadow      <= '0;
         seg_out     <= SEG_IDLE;
         dig_sel     <= DIG_IDLE;
         frame_start <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nx;
         idx         <= idx_nx;
         shadow      <= shadow_nx;
         seg_out     <= seg_nx;
         dig_sel     <= dig_nx;
         frame_start <= (state_nx == LOAD);
         busy        <= (state_nx != IDLE);
      end
   end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexing scheduler that shares one seven-segment bus (a..g) and a set of digit-select lines among NUM_DIGITS digit patterns produced by the core (s1..s8 style 7-bit patterns).
Once per frame it snapshots all patterns, then drives each digit in turn for a fixed dwell, with an anti-ghosting blank gap between digits.
Sits in the board top level on the 48 MHz oscillator clock, between the risc_v core's display outputs and the FPGA pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned; must be >= 1.
DWELL_CYCLES, 6000, clk cycles each digit is lit; must be >= 1 (125 us at 48 MHz).
BLANK_CYCLES, 48, clk cycles all digits are off between digits; 0 is legal and removes the gap.
SEG_ACTIVE_LOW, 0, 1 inverts seg_out so that a lit segment is driven 0.
DIG_ACTIVE_LOW, 1, 1 means the selected digit is driven 0 (common-anode boards).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
enable  input  1  scanning permitted; sampled at frame boundaries.
digits_in  input  7*NUM_DIGITS  digit k at bits [7k+6:7k]; within each digit, bit6=a ... bit0=g.
seg_out  output  7  segment drive, bit6=a ... bit0=g, after SEG_ACTIVE_LOW polarity.
dig_sel  output  NUM_DIGITS  one-hot digit select, bit k = digit k, after DIG_ACTIVE_LOW polarity.
frame_start  output  1  one-cycle pulse in the LOAD cycle.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous) forces: state IDLE; digit index 0; counter 0; shadow registers 0; frame_start 0; busy 0; seg_out and dig_sel at the inactive level. Inactive level: segments off, no digit selected, with both polarity parameters applied.
- All outputs are registered and reflect the current state, with no combinational path from inputs.
- IDLE: outputs inactive. enable=1 sampled in cycle T gives LOAD at T+1.
- LOAD (1 cycle): copy digits_in into shadow registers; index=0; frame_start=1; outputs inactive. Always goes to SHOW next.
- SHOW: seg_out = shadow[index]; dig_sel = onehot(index). Held for exactly DWELL_CYCLES cycles, then BLANK. If BLANK_CYCLES=0, go directly to the next-digit decision instead.
- BLANK: outputs inactive for exactly BLANK_CYCLES cycles. At the end of BLANK:
  - index < NUM_DIGITS-1: index+1, go to SHOW.
  - index = NUM_DIGITS-1 and enable=1: go to LOAD.
  - index = NUM_DIGITS-1 and enable=0: go to IDLE.
- enable falling mid-frame: the current frame completes all digits, then the block goes to IDLE. Scanning is never truncated, so every digit receives equal duty.
- Continuous frame period: 1 + NUM_DIGITS*(DWELL_CYCLES+BLANK_CYCLES) cycles.
- digits_in changes outside LOAD are ignored until the next LOAD, so there is no tearing within a frame.
- At most one dig_sel bit is active in any cycle. Within a frame, seg_out never changes while a digit is selected.
- Counter width: $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1). Index width: $clog2(NUM_DIGITS), minimum 1. Index never exceeds NUM_DIGITS-1.
- Reset asserted mid-SHOW blanks outputs immediately, without waiting for a clock edge. After release, the block restarts from IDLE at digit 0.

Decomposition:
- Package seg_scan_pkg:
  - state enum {IDLE, LOAD, SHOW, BLANK};
  - segment bit-position constants SEG_A=6 .. SEG_G=0;
  - SEG_OFF pattern 7'h00 (pre-polarity).
- One sub-module, seg_dwell_timer:
  - loadable down-counter with start/load value input;
  - done pulse on the last cycle;
  - shared by the SHOW and BLANK states.

Test Plan:
Bench parameters for tests 1-4: NUM_DIGITS=4, DWELL_CYCLES=3, BLANK_CYCLES=2, SEG_ACTIVE_LOW=0, DIG_ACTIVE_LOW=1. Initial digits_in: digit0=7'h7E, digit1=7'h30, digit2=7'h6D, digit3=7'h79.

1. Frame timing:
   - Stimulus: enable=1 sampled in cycle 0.
   - Required: frame_start in cycle 1.
   - Cycles 2-4: dig_sel=4'b1110, seg_out=7'h7E. Cycles 5-6: dig_sel=4'b1111, seg_out=7'h00.
   - Cycles 7-9: dig_sel=4'b1101, seg_out=7'h30.
   - Cycles 17-19: dig_sel=4'b0111, seg_out=7'h79.
   - Next frame_start in cycle 22 (period 21).
2. Snapshot:
   - Stimulus: set digit2 to 7'h33 in cycle 8.
   - Required: cycles 12-14 still show 7'h6D; 7'h33 first appears in cycles 33-35.
3. Disable mid-frame:
   - Stimulus: enable=0 in cycle 8.
   - Required: digits 2 and 3 still scan; busy falls at cycle 22; no frame_start at 22.
   - Stimulus: enable=1 again.
   - Required: LOAD, then digit0.
4. Async reset:
   - Stimulus: rst=0 in cycle 3 (between clock edges).
   - Required: dig_sel=4'b1111, seg_out=7'h00, busy=0 immediately.
   - Stimulus: release rst with enable=1.
   - Required: LOAD, then digit0.
5. BLANK_CYCLES=0:
   - Required: digits back-to-back (cycles 2-4, 5-7, 8-10, 11-13); frame_start at cycles 1 and 14.
   - Required: exactly one dig_sel bit active in every SHOW cycle.
6. SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=0:
   - Required: digit0 lit shows seg_out=7'h01, dig_sel=4'b0001.
   - Required: blank/idle shows seg_out=7'h7F, dig_sel=4'b0000.
